// File: rtl/hazard_defs.sv
// Shared definitions for the hazard/stall controller: FSM encoding, default
// sizing constants and the register-match helper used by both hazard terms.
package hazard_defs;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_MEM_TIMEOUT = 1024;
    localparam int DEF_TO_W        = 11;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_freeze;
    } hz_ctrl_t;

    // Held while rst is high: front end stopped and cleared, back end not frozen.
    localparam hz_ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0,
                                        if_id_flush: 1'b1, id_ex_bubble: 1'b1,
                                        pipe_freeze: 1'b0};

    localparam hz_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1,
                                      if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                      pipe_freeze: 1'b0};

    // x0 is hardwired zero, so a producer targeting it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic use1,
                                       input logic [4:0] rs2, input logic use2);
        return (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !(&count_q))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: load/ALU-in-EX
// interlocks, branch-on-load interlock, data-memory wait freeze and timeout.
module hazard_stall_unit
    import hazard_defs::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_W        = DEF_TO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             IF_ID_UsesRs1,
    input  logic             IF_ID_UsesRs2,
    input  logic             IF_ID_Branch,
    input  logic             branch_taken,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic [4:0]       EX_MEM_RegisterRd,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_e       state_q;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic     mem_access, freeze, raw_ex, br_load, hazard, take_branch;
    hz_ctrl_t ctrl;

    assign mem_access  = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign freeze      = mem_access & ~dmem_ready;

    // ALU results are forwarded only from MEM/WB, so any consumer of an EX
    // producer must wait one cycle; a load in MEM still has nothing to give
    // the ID-stage branch comparator.
    assign raw_ex      = ID_EX_RegWrite &
                         reg_match(ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_UsesRs1,
                                   IF_ID_RegisterRs2, IF_ID_UsesRs2);
    assign br_load     = IF_ID_Branch & EX_MEM_MemRead &
                         reg_match(EX_MEM_RegisterRd, IF_ID_RegisterRs1, IF_ID_UsesRs1,
                                   IF_ID_RegisterRs2, IF_ID_UsesRs2);
    assign hazard      = raw_ex | br_load;
    assign take_branch = IF_ID_Branch & branch_taken;

    always_comb begin
        ctrl = CTRL_RUN;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.pipe_freeze = 1'b1;
        end else if (hazard) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
        end else if (take_branch) begin
            ctrl.if_id_flush = 1'b1;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign pipe_freeze  = ctrl.pipe_freeze;

    // wait_cnt_d is the number of consecutive frozen cycles including this one;
    // it saturates at all-ones so it walks through MEM_TIMEOUT exactly once.
    always_comb begin
        wait_cnt_d = '0;
        if (freeze)
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + TO_W'(1);
        mem_timeout_d = mem_timeout_q;
        if (freeze && (MEM_TIMEOUT != 0) && (wait_cnt_d == TO_W'(MEM_TIMEOUT)))
            mem_timeout_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            case (state_q)
                RUN:      if (freeze)     state_q <= MEM_WAIT;
                MEM_WAIT: if (dmem_ready) state_q <= RUN;
                default:                  state_q <= RUN;
            endcase
        end
    end

    assign mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~ctrl.pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.if_id_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized checks of hazard_stall_unit against a cycle-level
// reference model built from the hazard/freeze priority rules.
module tb_hazard_stall_unit;
    import hazard_defs::*;

    localparam int CW = 6;
    localparam int MT = 4;
    localparam int TW = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int WMAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1, rs2, ex_rd, mem_rd_reg;
    logic u1, u2, br, taken, ex_rw, m_rd, m_wr, ready;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    int errs = 0;
    int checks = 0;

    // reference model state
    int m_stall, m_flush, m_wait;
    bit m_to, m_wait_st;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(CW), .MEM_TIMEOUT(MT), .TO_W(TW)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
        .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
        .IF_ID_Branch(br), .branch_taken(taken),
        .ID_EX_RegWrite(ex_rw), .ID_EX_RegisterRd(ex_rd),
        .EX_MEM_MemRead(m_rd), .EX_MEM_MemWrite(m_wr), .EX_MEM_RegisterRd(mem_rd_reg),
        .dmem_ready(ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; br = 0; taken = 0;
        ex_rw = 0; ex_rd = 0; m_rd = 0; m_wr = 0; mem_rd_reg = 0; ready = 1;
    endtask

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0; m_wait_st = 0;
    endtask

    // Checks one cycle against the model, then advances across the next edge.
    task automatic step(input string tag);
        bit fr, raw, brl, e_pc, e_ifw, e_fl, e_bub, e_frz;
        #2;
        fr  = (m_rd || m_wr) && !ready;
        raw = ex_rw && ex_rd != 0 && ((u1 && ex_rd == rs1) || (u2 && ex_rd == rs2));
        brl = br && m_rd && mem_rd_reg != 0 &&
              ((u1 && mem_rd_reg == rs1) || (u2 && mem_rd_reg == rs2));
        if (rst) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1; e_frz = 0;
        end else if (fr) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_frz = 1;
        end else if (raw || brl) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; e_frz = 0;
        end else begin
            e_pc = 1; e_ifw = 1; e_fl = br && taken; e_bub = 0; e_frz = 0;
        end
        chk({tag, "/pc_write"},     32'(pc_write),     32'(e_pc));
        chk({tag, "/if_id_write"},  32'(if_id_write),  32'(e_ifw));
        chk({tag, "/if_id_flush"},  32'(if_id_flush),  32'(e_fl));
        chk({tag, "/id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
        chk({tag, "/pipe_freeze"},  32'(pipe_freeze),  32'(e_frz));
        chk({tag, "/mem_timeout"},  32'(mem_timeout),  32'(m_to));
        chk({tag, "/stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        chk({tag, "/flush_count"},  32'(flush_count),  32'(m_flush));
        chk({tag, "/state"},        32'(dut.state_q),  32'(m_wait_st));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (e_fl && m_flush < CMAX) m_flush++;
            if (fr) begin
                if (m_wait < WMAX) m_wait++;
                if (m_wait == MT) m_to = 1;
            end else begin
                m_wait = 0;
            end
            if (!m_wait_st) m_wait_st = fr;
            else if (ready) m_wait_st = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        @(posedge clk); #1;

        // reset state
        step("por");
        rst = 1'b0;
        step("idle");

        // ALU RAW on x5 in EX: one bubble cycle
        do_reset();
        ex_rw = 1; ex_rd = 5; rs1 = 5; u1 = 1; rs2 = 9; u2 = 1;
        step("raw_ex");
        ex_rw = 0;
        step("raw_done");
        chk("raw_stall_total", 32'(stall_cycles), 32'd1);

        // branch on a load to x7: two stalls, then a taken-branch flush
        do_reset();
        ex_rw = 1; ex_rd = 7; br = 1; rs1 = 7; u1 = 1; rs2 = 2; u2 = 1;
        step("brload_ex");
        ex_rw = 0; m_rd = 1; mem_rd_reg = 7; ready = 1;
        step("brload_mem");
        m_rd = 0; taken = 1;
        step("brload_taken");
        idle_inputs();
        step("brload_after");
        chk("brload_stalls", 32'(stall_cycles), 32'd2);
        chk("brload_flushes", 32'(flush_count), 32'd1);

        // x0 never interlocks
        do_reset();
        ex_rw = 1; ex_rd = 0; rs1 = 0; u1 = 1;
        step("x0_raw");
        chk("x0_pc_write", 32'(pc_write), 32'd1);

        // store waits 3 cycles while an EX hazard is also pending
        do_reset();
        m_wr = 1; ready = 0; ex_rw = 1; ex_rd = 3; rs2 = 3; u2 = 1;
        for (int i = 0; i < 3; i++) step("store_wait");
        chk("store_state_wait", 32'(dut.state_q), 32'(MEM_WAIT));
        ready = 1; ex_rw = 0;
        step("store_ready");
        chk("store_state_run", 32'(dut.state_q), 32'(RUN));
        chk("store_stalls", 32'(stall_cycles), 32'd3);

        // timeout after MT frozen cycles, sticky until reset
        do_reset();
        m_rd = 1; mem_rd_reg = 4; ready = 0;
        for (int i = 0; i < MT + 2; i++) step("timeout");
        chk("timeout_set", 32'(mem_timeout), 32'd1);
        do_reset();
        chk("timeout_cleared", 32'(mem_timeout), 32'd0);

        // asynchronous reset in the middle of MEM_WAIT
        m_wr = 1; ready = 0;
        step("async_a");
        step("async_b");
        #2 rst = 1'b1;
        #1;
        chk("async_state", 32'(dut.state_q), 32'(RUN));
        chk("async_stall", 32'(stall_cycles), 32'd0);
        chk("async_pc_write", 32'(pc_write), 32'd0);
        chk("async_bubble", 32'(id_ex_bubble), 32'd1);
        chk("async_flush", 32'(if_id_flush), 32'd1);
        chk("async_freeze", 32'(pipe_freeze), 32'd0);
        model_reset();
        @(posedge clk); #1;
        step("async_hold");
        rst = 1'b0;
        idle_inputs();

        // stall counter saturation
        do_reset();
        ex_rw = 1; ex_rd = 1; rs1 = 1; u1 = 1;
        for (int i = 0; i < CMAX + 6; i++) step("sat");
        chk("stall_saturated", 32'(stall_cycles), 32'(CMAX));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            u1 = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1)); taken = 1'($urandom_range(0, 1));
            ex_rw = 1'($urandom_range(0, 1)); ex_rd = 5'($urandom_range(0, 3));
            m_rd = ($urandom_range(0, 3) == 0); m_wr = ($urandom_range(0, 3) == 0);
            mem_rd_reg = 5'($urandom_range(0, 3));
            ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 59) == 0);
            if (rst) model_reset();
            step("rand");
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
